// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  // Data bits per frame and oversampling phase at which a bit is consumed.
  localparam int unsigned DATA_WIDTH = 8;
  localparam logic [2:0]  LAST_EDGE  = 3'd7;

  // Frame bit indices as reported by the edge/bit counter.
  localparam logic [3:0] START_IDX     = 4'd0;
  localparam logic [3:0] LAST_DATA_IDX = 4'd8;

  // Frame controller states; IDLE must encode as zero.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/uart_rx_deserializer.sv
// LSB-first shift register for the received data bits, with a running
// XOR-reduction of the collected byte for the parity check.
module uart_rx_deserializer
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  shift_en,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  parity
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // New bits enter at the MSB so the first received bit ends up at the LSB.
  always_comb begin
    data_d = data_q;
    if (shift_en) begin
      data_d = {bit_in, data_q[DATA_WIDTH-1:1]};
    end
  end

  // Byte register; cleared by reset so a partial frame never leaks out.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data   = data_q;
  assign parity = ^data_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: sequences start/data/parity/stop bits from
// the oversampling counter's ticks, checks framing and emits the byte.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [2:0]            edge_count,
  input  logic [3:0]            bit_count,
  input  logic                  sampled_bit,
  output logic                  cnt_enable,
  output logic                  smp_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  state_e state_q, state_d;
  logic   active_q, active_d;
  logic   par_en_q, par_en_d;
  logic   par_typ_q, par_typ_d;
  logic   data_valid_q, data_valid_d;
  logic   par_err_q, par_err_d;
  logic   stp_err_q, stp_err_d;

  logic   tick;
  logic   shift_en;
  logic   frame_start;
  logic   data_parity;

  // A bit period completes on the last oversampling edge; the counter wraps
  // on the same clock, so bit_count here is still the index of this bit.
  assign tick = active_q && (edge_count == LAST_EDGE);

  // Next-state, frame configuration latch and error/valid flag computation.
  always_comb begin
    state_d      = state_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    data_valid_d = 1'b0;
    shift_en     = 1'b0;
    frame_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d     = ST_START;
          frame_start = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          // A high start bit at mid-period is treated as line noise.
          state_d = sampled_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_count == LAST_DATA_IDX) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          par_err_d = (sampled_bit != (data_parity ^ par_typ_q));
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          stp_err_d    = ~sampled_bit;
          data_valid_d = sampled_bit && !par_err_q;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        // A line still low here is the start bit of a back-to-back frame.
        if (!RX_IN) begin
          state_d     = ST_START;
          frame_start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Parity configuration is frozen and stale errors dropped per frame.
    if (frame_start) begin
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
    end

    active_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // FSM state and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      active_q     <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  uart_rx_deserializer u_deser (
    .CLK      (CLK),
    .RST      (RST),
    .shift_en (shift_en),
    .bit_in   (sampled_bit),
    .data     (P_DATA),
    .parity   (data_parity)
  );

  assign cnt_enable = active_q;
  assign smp_enable = active_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: models the upstream edge/bit counter and the
// sampler (bit value chosen per frame index), and predicts each frame's
// outcome from the UART framing rules.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [2:0] edge_count = '0;
  logic [3:0] bit_count = '0;
  logic       sampled_bit;
  logic       cnt_enable;
  logic       smp_enable;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  // Line value of each frame bit, indexed by the counter's bit index.
  logic [15:0] fbits = '1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .sampled_bit (sampled_bit),
    .cnt_enable  (cnt_enable),
    .smp_enable  (smp_enable),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Upstream 8x oversampling counter: clears while disabled.
  always @(posedge CLK) begin
    if (!RST || !cnt_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else begin
      edge_count <= edge_count + 3'd1;
      if (edge_count == 3'd7) bit_count <= bit_count + 4'd1;
    end
  end

  assign sampled_bit = fbits[bit_count];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one frame starting at the next edge and check it. Cycle k is the
  // cycle following clock edge k-1, so the first sample below is cycle N+1
  // where N is the edge that sees the falling line.
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic pbit, input logic stopb, input logic keep_low);
    int   lat_exp;
    int   dv_lat;
    int   dv_cnt;
    logic exp_pe;
    logic exp_se;
    logic exp_dv;
    lat_exp = pen ? 89 : 81;
    exp_pe  = pen && (pbit != ((^d) ^ ptyp));
    exp_se  = !stopb;
    exp_dv  = !exp_pe && !exp_se;

    fbits = '1;
    fbits[START_IDX] = 1'b0;
    fbits[8:1] = d;
    if (pen) begin
      fbits[9]  = pbit;
      fbits[10] = stopb;
    end else begin
      fbits[9] = stopb;
    end
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    RX_IN   = 1'b0;
    dv_lat  = 0;
    dv_cnt  = 0;

    for (int lat = 1; lat <= lat_exp; lat++) begin
      @(negedge CLK);
      if (data_valid) begin
        dv_cnt++;
        if (dv_lat == 0) dv_lat = lat;
      end
      if (lat == 1) begin
        check_val("cnt_en_start", 32'(cnt_enable), 32'd1);
        check_val("smp_en_start", 32'(smp_enable), 32'd1);
        check_val("flags_cleared", 32'({par_err, stp_err}), 32'd0);
        if (!keep_low) RX_IN = 1'b1;
        // Mid-frame configuration changes must be ignored.
        PAR_EN  = 1'($urandom_range(0, 1));
        PAR_TYP = 1'($urandom_range(0, 1));
      end
    end
    check_val("p_data", 32'(P_DATA), 32'(d));
    check_val("par_err", 32'(par_err), 32'(exp_pe));
    check_val("stp_err", 32'(stp_err), 32'(exp_se));
    check_val("cnt_en_done", 32'(cnt_enable), 32'd0);
    check_val("dv_count", 32'(dv_cnt), exp_dv ? 32'd1 : 32'd0);
    check_val("dv_latency", 32'(dv_lat), exp_dv ? 32'(lat_exp) : 32'd0);

    if (!keep_low) begin
      dv_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        if (data_valid) dv_cnt++;
      end
      check_val("dv_one_cycle", 32'(dv_cnt), 32'd0);
      check_val("idle_cnt_en", 32'(cnt_enable), 32'd0);
      check_val("p_data_hold", 32'(P_DATA), 32'(d));
      check_val("par_err_hold", 32'(par_err), 32'(exp_pe));
    end
  endtask

  // Short low pulse whose start bit samples high: must abort back to idle.
  task automatic run_glitch();
    int dv_cnt;
    fbits = '1;
    RX_IN = 1'b0;
    dv_cnt = 0;
    for (int lat = 1; lat <= 24; lat++) begin
      @(negedge CLK);
      if (data_valid) dv_cnt++;
      if (lat == 2) RX_IN = 1'b1;
      if (lat == 8) check_val("glitch_cnt_en_tick", 32'(cnt_enable), 32'd1);
      if (lat == 9) check_val("glitch_cnt_en_after", 32'(cnt_enable), 32'd0);
    end
    check_val("glitch_no_dv", 32'(dv_cnt), 32'd0);
    check_val("glitch_flags", 32'({par_err, stp_err}), 32'd0);
    check_val("glitch_idle", 32'(cnt_enable), 32'd0);
  endtask

  // Reset in the middle of the data bits.
  task automatic run_reset_mid();
    int   dv_cnt;
    logic found;
    fbits = '1;
    fbits[START_IDX] = 1'b0;
    fbits[8:1] = 8'hC3;
    PAR_EN = 1'b0;
    RX_IN  = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
      if (cnt_enable && bit_count == 4'd4 && edge_count == 3'd3) found = 1'b1;
    end
    check_val("reset_reach_bit4", 32'(found), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    check_val("rst_cnt_en", 32'(cnt_enable), 32'd0);
    check_val("rst_p_data", 32'(P_DATA), 32'd0);
    check_val("rst_flags", 32'({data_valid, par_err, stp_err}), 32'd0);
    dv_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (data_valid) dv_cnt++;
    end
    check_val("rst_no_dv", 32'(dv_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pen, ptyp, pbit, stopb, kl;

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("reset_cnt_en", 32'(cnt_enable), 32'd0);
    check_val("reset_smp_en", 32'(smp_enable), 32'd0);
    check_val("reset_p_data", 32'(P_DATA), 32'd0);
    check_val("reset_flags", 32'({data_valid, par_err, stp_err}), 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_glitch();
    run_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_reset_mid();
    run_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom_range(0, 1));
      ptyp  = 1'($urandom_range(0, 1));
      pbit  = 1'($urandom_range(0, 1));
      stopb = ($urandom_range(0, 3) != 0);
      kl    = (i < 11) && ($urandom_range(0, 2) == 0);
      run_frame(d, pen, ptyp, pbit, stopb, kl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Frame controller for the UART receiver. It consumes the edge and bit counts from the oversampling edge/bit counter and the majority-voted bit from the data sampler.
- It drives the counter and sampler enables, deserialises the data bits LSB-first, and checks start, parity and stop bits.
- It emits the received byte with a one-cycle valid pulse.
- It sits between the counter/sampler pair (upstream) and the RX output interface (downstream).
- Oversampling is fixed at 8 edges per bit.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (fixed at 8 for this block).
- LAST_EDGE, 3'd7, edge_count value at which a bit period completes and sampled_bit is consumed.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-low.
- RX_IN  in  1  serial line, already synchronised; idle high.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- edge_count  in  3  edge counter value from the edge/bit counter.
- bit_count  in  4  frame bit index from the edge/bit counter (0 = start bit).
- sampled_bit  in  1  sampler output; guaranteed stable when edge_count == LAST_EDGE.
- cnt_enable  out  1  enables the edge/bit counter; counter clears while low.
- smp_enable  out  1  enables the data sampler.
- P_DATA  out  8  received byte, LSB = first data bit.
- data_valid  out  1  one-cycle pulse: P_DATA is a good frame.
- par_err  out  1  parity mismatch in the last frame.
- stp_err  out  1  stop bit sampled low in the last frame.

Behaviour:
- Reset (RST low at a CLK edge): state = IDLE; P_DATA = 0; data_valid, par_err and stp_err = 0. cnt_enable and smp_enable are Moore outputs and therefore 0.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- cnt_enable and smp_enable = 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- Decision point ("tick"): edge_count == LAST_EDGE while cnt_enable = 1. All bit consumption happens only on a tick.
- IDLE:
  - On RX_IN == 0: go to START.
  - Latch PAR_EN and PAR_TYP into internal registers; these hold for the whole frame.
  - Clear par_err and stp_err.
- START, on tick:
  - sampled_bit == 1 (glitch): go to IDLE. No data_valid; error flags stay 0.
  - Otherwise: go to DATA.
- DATA, on tick:
  - Shift: P_DATA <= {sampled_bit, P_DATA[7:1]}.
  - If bit_count == 8: go to PARITY when latched PAR_EN = 1, else to STOP.
- PARITY, on tick:
  - Expected parity bit = (^P_DATA) XOR latched PAR_TYP.
  - par_err <= (sampled_bit != expected).
  - Go to STOP.
- STOP, on tick:
  - stp_err <= ~sampled_bit.
  - Go to DONE.
- DONE, single cycle:
  - data_valid = 1 iff par_err == 0 and stp_err == 0 (registered on the transition into DONE).
  - Next state is START if RX_IN == 0 (back-to-back frame, PAR_EN/PAR_TYP re-latched, flags cleared), else IDLE.
- Latency: with the falling RX_IN seen at edge N, START is entered at N+1 and a tick occurs every 8 cycles.
  - No parity: data_valid high in cycle N+81.
  - With parity: data_valid high in cycle N+89.
- P_DATA holds its value from DONE until the next DATA shift. par_err and stp_err hold until the next frame start.
- Counter wrap: the counter's wrap (edge 7→0, bit_count+1) coincides with the FSM tick. The FSM uses the pre-increment bit_count.
- PAR_EN/PAR_TYP changes mid-frame are ignored.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. No data_valid for the partial frame.
- Line held low after a failed stop bit: DONE → START. The next frame is processed normally.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (3-bit encoding, IDLE = 0);
  - LAST_EDGE;
  - DATA_WIDTH;
  - frame bit index constants (START_IDX = 0, LAST_DATA_IDX = 8).
- One natural sub-module, uart_rx_deserializer: shift register plus parity compute, enabled by the FSM's shift strobe. The FSM and error flags stay in uart_rx_fsm.

Test Plan:
- Frame 0xA5, PAR_EN = 0, clean line → P_DATA = 0xA5, data_valid for exactly 1 cycle at N+81, par_err = 0, stp_err = 0.
- Frame 0x3C, PAR_EN = 1, PAR_TYP = 0, parity bit 0 → data_valid at N+89, par_err = 0. Same frame with parity bit 1 → par_err = 1, no data_valid.
- Frame 0x81, PAR_EN = 1, PAR_TYP = 1, parity bit 1 → P_DATA = 0x81, data_valid, par_err = 0.
- Start glitch: RX_IN low for 2 cycles, sampled_bit = 1 at first tick → return to IDLE at tick+1, cnt_enable = 0, no data_valid.
- Stop bit low on frame 0x55 → stp_err = 1, no data_valid. Immediate second frame 0xAA → DONE→START, P_DATA = 0xAA, data_valid, stp_err cleared.
- RST asserted low during DATA at bit_count = 4 → next cycle IDLE, P_DATA = 0, all flags 0. The following clean frame 0x0F is received correctly.
